// File: rtl/conf_timing_sequencer.sv
// Morse timing configuration: BCD options to pulse counts.
// One shared BCD converter and one shift-add multiplier, sequenced.
module conf_timing_sequencer #(
  parameter int DIGITS = 6,
  parameter int HALF_W = 20,
  parameter int OUT_W  = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                update,
  input  logic [4*DIGITS-1:0] dit_units,
  input  logic [4*DIGITS-1:0] dah_units,
  input  logic [4*DIGITS-1:0] word_units,
  input  logic [4*DIGITS-1:0] tol_units,
  input  logic [4*DIGITS-1:0] pulses_per_unit,
  output logic [OUT_W-1:0]    dit_time,
  output logic [OUT_W-1:0]    dah_time,
  output logic [OUT_W-1:0]    word_time,
  output logic [OUT_W-1:0]    tol_time,
  output logic                busy,
  output logic                ready,
  output logic                bcd_err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int MAX_C = (HALF_W > DIGITS) ? HALF_W : DIGITS;
  localparam int CW    = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CONV_PPU,
    CONV_U,
    MUL,
    STORE
  } state_t;

  state_t state_q, state_d;

  logic [BCD_W-1:0]  unit_lat [4];
  logic [BCD_W-1:0]  dsr_q;
  logic [HALF_W-1:0] acc_q;
  logic [HALF_W-1:0] ppu_bin_q;
  logic [HALF_W-1:0] mplr_q;
  logic [OUT_W-1:0]  mcand_q;
  logic [OUT_W-1:0]  prod_q;
  logic [OUT_W-1:0]  time_q [4];
  logic [CW-1:0]     cnt_q;
  logic [1:0]        fld_q;
  logic              busy_q;
  logic              ready_q;
  logic              err_q;

  logic [3:0]        nib;
  logic [3:0]        dig;
  logic              nib_bad;
  logic [HALF_W-1:0] acc_nxt;
  logic              last_dig;
  logic              last_bit;

  // Digits arrive MSD first from the top of the shift register.
  always_comb begin
    nib      = dsr_q[BCD_W-1 -: 4];
    nib_bad  = (nib > 4'd9);
    dig      = nib_bad ? 4'd9 : nib;
    acc_nxt  = acc_q * HALF_W'(10) + HALF_W'(dig);
    last_dig = (cnt_q == CW'(DIGITS - 1));
    last_bit = (cnt_q == CW'(HALF_W - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = IDLE;
      CONV_PPU: if (last_dig) state_d = CONV_U;
      CONV_U:   if (last_dig) state_d = MUL;
      MUL:      if (last_bit) state_d = STORE;
      STORE:    state_d = (fld_q == 2'd3) ? IDLE : CONV_U;
      default:  state_d = IDLE;
    endcase
    if (update) state_d = CONV_PPU;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else if (ce) state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unit_lat  <= '{default: '0};
      dsr_q     <= '0;
      acc_q     <= '0;
      ppu_bin_q <= '0;
      mplr_q    <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      time_q    <= '{default: '0};
      cnt_q     <= '0;
      fld_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else if (ce) begin
      if (update) begin
        unit_lat <= '{dit_units, dah_units,
                      word_units, tol_units};
        dsr_q    <= pulses_per_unit;
        acc_q    <= '0;
        cnt_q    <= '0;
        fld_q    <= '0;
        err_q    <= 1'b0;
        ready_q  <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        unique case (state_q)
          CONV_PPU: begin
            err_q <= err_q | nib_bad;
            if (last_dig) begin
              ppu_bin_q <= acc_nxt;
              acc_q     <= '0;
              cnt_q     <= '0;
              dsr_q     <= unit_lat[0];
            end else begin
              acc_q <= acc_nxt;
              cnt_q <= cnt_q + CW'(1);
              dsr_q <= dsr_q << 4;
            end
          end
          CONV_U: begin
            err_q <= err_q | nib_bad;
            if (last_dig) begin
              mplr_q  <= acc_nxt;
              mcand_q <= OUT_W'(ppu_bin_q);
              prod_q  <= '0;
              acc_q   <= '0;
              cnt_q   <= '0;
            end else begin
              acc_q <= acc_nxt;
              cnt_q <= cnt_q + CW'(1);
              dsr_q <= dsr_q << 4;
            end
          end
          MUL: begin
            if (mplr_q[0]) prod_q <= prod_q + mcand_q;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= last_bit ? '0 : cnt_q + CW'(1);
          end
          STORE: begin
            time_q[fld_q] <= prod_q;
            if (fld_q == 2'd3) begin
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              fld_q <= fld_q + 2'd1;
              dsr_q <= unit_lat[fld_q + 2'd1];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dit_time  = time_q[0];
  assign dah_time  = time_q[1];
  assign word_time = time_q[2];
  assign tol_time  = time_q[3];
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign bcd_err   = err_q;

endmodule
